// File: rtl/demux_stream.sv
// Registered 1-to-OUT_NUM stream demultiplexer with a single-entry output stage.
// Words whose select is beyond the last channel are consumed, dropped and counted.
module demux_stream #(
    parameter int SEL_WIDTH = 4,
    parameter int OUT_NUM   = 16,
    parameter int IN_WIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [SEL_WIDTH-1:0] in_sel,
    input  logic [IN_WIDTH-1:0]  in_data,
    output logic [OUT_NUM-1:0]   out_valid,
    input  logic [OUT_NUM-1:0]   out_ready,
    output logic [IN_WIDTH-1:0]  out_data,
    output logic                 err_pulse,
    output logic [7:0]           err_count
);

    localparam logic [31:0] OUT_NUM_W = 32'(OUT_NUM);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t state;
    logic   in_range;
    logic   accept;
    logic   drain;

    function automatic logic [OUT_NUM-1:0] sel_onehot(input logic [SEL_WIDTH-1:0] sel);
        logic [OUT_NUM-1:0] oh;
        oh = '0;
        for (int k = 0; k < OUT_NUM; k++) begin
            if (32'(k) == 32'(sel)) oh[k] = 1'b1;
        end
        return oh;
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] cnt);
        return (cnt == 8'hFF) ? cnt : cnt + 8'd1;
    endfunction

    // out_valid is one-hot of the held select while FULL, so masking the
    // ready vector with it picks out exactly the selected consumer's ready.
    assign in_range = 32'(in_sel) < OUT_NUM_W;
    assign drain    = (state == FULL) && ((out_valid & out_ready) != '0);
    assign in_ready = !rst && ((state == EMPTY) || drain);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= EMPTY;
            out_valid <= '0;
            out_data  <= '0;
            err_pulse <= 1'b0;
            err_count <= 8'd0;
        end else begin
            err_pulse <= accept && !in_range;
            if (accept && !in_range) begin
                err_count <= sat_inc(err_count);
            end
            // A dropped word leaves the output stage exactly as if nothing was accepted.
            if (accept && in_range) begin
                state     <= FULL;
                out_valid <= sel_onehot(in_sel);
                out_data  <= in_data;
            end else if (drain) begin
                state     <= EMPTY;
                out_valid <= '0;
            end
        end
    end

endmodule
